// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into HOLD_CYCLES-long level bursts,
// separated by at least GAP_CYCLES low cycles, with a saturating pending queue.
module pulse_stretch #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000,
  parameter int unsigned MAX_PEND    = 7,
  localparam int unsigned PW         = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  input  logic          ovf_clr,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          ovf
);

  localparam int unsigned MaxCyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GapLast  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PendMax  = PW'(MAX_PEND);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          level_q, busy_q;
  logic          burst_start;
  logic          ovf_set;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    burst_start = 1'b0;
    ovf_set     = 1'b0;

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (pulse_in) state_d = StHold;
      end
      StHold: begin
        if (timer_q == HoldLast) begin
          state_d = StGap;
          timer_d = '0;
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          // Chain straight into the next burst, no idle cycle in between.
          if ((pend_q != '0) || pulse_in) begin
            state_d     = StHold;
            burst_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    // A pulse arriving with the burst start is either consumed directly
    // (empty queue) or swaps in for the one dequeued.
    if (state_q != StIdle) begin
      if (burst_start) begin
        if ((pend_q != '0) && !pulse_in) pend_d = pend_q - PW'(1);
      end else if (pulse_in) begin
        if (pend_q == PendMax) ovf_set = 1'b1;
        else                   pend_d  = pend_q + PW'(1);
      end
    end

    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == StHold);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule
